// File: rtl/regfile_csr_unit_pkg.sv
// Shared constants for the GPR file and machine-mode CSR block.
// CSR addresses, commit op encodings and mstatus field positions.
package regfile_csr_unit_pkg;

   localparam logic [11:0] CSR_MSTATUS   = 12'h300;
   localparam logic [11:0] CSR_MTVEC     = 12'h305;
   localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
   localparam logic [11:0] CSR_MEPC      = 12'h341;
   localparam logic [11:0] CSR_MCAUSE    = 12'h342;
   localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
   localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
   localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
   localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

   typedef enum logic [2:0] {
      OP_NONE  = 3'd0,
      OP_RW    = 3'd1,
      OP_RS    = 3'd2,
      OP_RC    = 3'd3,
      OP_ECALL = 3'd4,
      OP_MRET  = 3'd5
   } csr_op_e;

   localparam int MSTATUS_MIE    = 3;
   localparam int MSTATUS_MPIE   = 7;
   localparam int MSTATUS_MPP_LO = 11;
   localparam int MSTATUS_MPP_HI = 12;

   function automatic logic csr_implemented(input logic [11:0] a);
      case (a)
         CSR_MSTATUS, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE,
         CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH:
            csr_implemented = 1'b1;
         default: csr_implemented = 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] mstatus_pack(input logic mie,
                                                input logic mpie);
      logic [31:0] v;
      v = '0;
      v[MSTATUS_MIE] = mie;
      v[MSTATUS_MPIE] = mpie;
      v[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
      return v;
   endfunction

endpackage

// File: rtl/regfile_csr_unit_counter64.sv
// 64-bit counter with per-half write port; a write suppresses
// the increment of both halves for that cycle.
module csr_counter64 (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_inc,
   input  logic        i_wr_lo,
   input  logic        i_wr_hi,
   input  logic [31:0] i_wdata,
   output logic [63:0] o_value
);

   logic [31:0] r_lo;
   logic [31:0] r_hi;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_lo <= '0;
         r_hi <= '0;
      end else if (i_wr_lo) begin
         r_lo <= i_wdata;
      end else if (i_wr_hi) begin
         r_hi <= i_wdata;
      end else if (i_inc) begin
         {r_hi, r_lo} <= {r_hi, r_lo} + 64'd1;
      end
   end

   assign o_value = {r_hi, r_lo};

endmodule

// File: rtl/regfile_csr_unit.sv
// Integer register file plus machine-mode CSRs, trap entry/return
// and cycle/instret counters.
module regfile_csr_unit
   import regfile_csr_unit_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int NREG   = 32,
   parameter bit BYPASS = 1'b1,
   localparam int AW    = $clog2(NREG)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [AW-1:0]   rs1_addr,
   input  logic [AW-1:0]   rs2_addr,
   output logic [XLEN-1:0] rs1_data,
   output logic [XLEN-1:0] rs2_data,
   input  logic            wb_wen,
   input  logic [AW-1:0]   wb_rd,
   input  logic [XLEN-1:0] wb_data,
   input  logic [11:0]     csr_raddr,
   output logic [XLEN-1:0] csr_rdata,
   input  logic [2:0]      csr_op,
   input  logic [11:0]     csr_addr,
   input  logic [XLEN-1:0] csr_wdata,
   input  logic            csr_wr_suppress,
   input  logic [XLEN-1:0] trap_pc,
   input  logic [XLEN-1:0] trap_cause,
   input  logic            retire,
   output logic [XLEN-1:0] mtvec_o,
   output logic [XLEN-1:0] mepc_o,
   output logic            mie_o,
   output logic            illegal_csr
);

   logic [XLEN-1:0] r_gpr [NREG];
   logic            r_mie;
   logic            r_mpie;
   logic [XLEN-1:0] r_mtvec;
   logic [XLEN-1:0] r_mscratch;
   logic [XLEN-1:0] r_mepc;
   logic [XLEN-1:0] r_mcause;
   logic            r_illegal;

   logic [63:0]     w_mcycle;
   logic [63:0]     w_minstret;
   logic            w_is_csr;
   logic            w_hit;
   logic            w_do_wr;
   logic [XLEN-1:0] w_old;
   logic [XLEN-1:0] w_new;

   // x0 never takes a write, so r_gpr[0] stays zero as well
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) r_gpr[i] <= '0;
      end else if (wb_wen && wb_rd != '0) begin
         r_gpr[wb_rd] <= wb_data;
      end
   end

   function automatic logic [XLEN-1:0] gpr_read(input logic [AW-1:0] a);
      if (a == '0) return '0;
      if (BYPASS && wb_wen && wb_rd == a) return wb_data;
      return r_gpr[a];
   endfunction

   assign rs1_data = gpr_read(rs1_addr);
   assign rs2_data = gpr_read(rs2_addr);

   function automatic logic [XLEN-1:0] csr_read(input logic [11:0] a);
      case (a)
         CSR_MSTATUS:   csr_read = mstatus_pack(r_mie, r_mpie);
         CSR_MTVEC:     csr_read = r_mtvec;
         CSR_MSCRATCH:  csr_read = r_mscratch;
         CSR_MEPC:      csr_read = r_mepc;
         CSR_MCAUSE:    csr_read = r_mcause;
         CSR_MCYCLE:    csr_read = w_mcycle[31:0];
         CSR_MCYCLEH:   csr_read = w_mcycle[63:32];
         CSR_MINSTRET:  csr_read = w_minstret[31:0];
         CSR_MINSTRETH: csr_read = w_minstret[63:32];
         default:       csr_read = '0;
      endcase
   endfunction

   assign csr_rdata = csr_read(csr_raddr);

   assign w_is_csr = (csr_op == OP_RW) || (csr_op == OP_RS) ||
                     (csr_op == OP_RC);
   assign w_hit    = csr_implemented(csr_addr);
   assign w_old    = csr_read(csr_addr);
   assign w_do_wr  = w_is_csr && w_hit &&
                     ((csr_op == OP_RW) || !csr_wr_suppress);

   always_comb begin
      w_new = csr_wdata;
      case (csr_op)
         OP_RS:   w_new = w_old | csr_wdata;
         OP_RC:   w_new = w_old & ~csr_wdata;
         default: w_new = csr_wdata;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_mie      <= 1'b0;
         r_mpie     <= 1'b0;
         r_mtvec    <= '0;
         r_mscratch <= '0;
         r_mepc     <= '0;
         r_mcause   <= '0;
         r_illegal  <= 1'b0;
      end else begin
         r_illegal <= w_is_csr && !w_hit;
         if (w_do_wr) begin
            case (csr_addr)
               CSR_MSTATUS: begin
                  r_mie  <= w_new[MSTATUS_MIE];
                  r_mpie <= w_new[MSTATUS_MPIE];
               end
               CSR_MTVEC:    r_mtvec    <= {w_new[XLEN-1:2], 2'b00};
               CSR_MSCRATCH: r_mscratch <= w_new;
               CSR_MEPC:     r_mepc     <= {w_new[XLEN-1:2], 2'b00};
               CSR_MCAUSE:   r_mcause   <= w_new;
               default: ;
            endcase
         end
         if (csr_op == OP_ECALL) begin
            r_mepc   <= {trap_pc[XLEN-1:2], 2'b00};
            r_mcause <= trap_cause;
            r_mpie   <= r_mie;
            r_mie    <= 1'b0;
         end else if (csr_op == OP_MRET) begin
            r_mie  <= r_mpie;
            r_mpie <= 1'b1;
         end
      end
   end

   csr_counter64 u_mcycle (
      .clk     (clk),
      .rst     (rst),
      .i_inc   (1'b1),
      .i_wr_lo (w_do_wr && csr_addr == CSR_MCYCLE),
      .i_wr_hi (w_do_wr && csr_addr == CSR_MCYCLEH),
      .i_wdata (w_new),
      .o_value (w_mcycle)
   );

   csr_counter64 u_minstret (
      .clk     (clk),
      .rst     (rst),
      .i_inc   (retire),
      .i_wr_lo (w_do_wr && csr_addr == CSR_MINSTRET),
      .i_wr_hi (w_do_wr && csr_addr == CSR_MINSTRETH),
      .i_wdata (w_new),
      .o_value (w_minstret)
   );

   assign mtvec_o     = r_mtvec;
   assign mepc_o      = r_mepc;
   assign mie_o       = r_mie;
   assign illegal_csr = r_illegal;

endmodule

// File: tb/tb_regfile_csr_unit.sv
// Directed bench for regfile_csr_unit with a queue-based scoreboard;
// a second instance runs with forwarding disabled.
module tb_regfile_csr_unit;
   import regfile_csr_unit_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  rs1_addr, rs2_addr, wb_rd;
   logic [31:0] rs1_data, rs2_data, nb_rs1, nb_rs2;
   logic        wb_wen;
   logic [31:0] wb_data;
   logic [11:0] csr_raddr, csr_addr;
   logic [31:0] csr_rdata, nb_csr_rdata;
   logic [2:0]  csr_op;
   logic [31:0] csr_wdata, trap_pc, trap_cause;
   logic        csr_wr_suppress, retire;
   logic [31:0] mtvec_o, mepc_o, nb_mtvec, nb_mepc;
   logic        mie_o, illegal_csr, nb_mie, nb_illegal;

   int n_vec = 0;
   int n_mis = 0;
   logic [31:0] q_exp[$];
   string       q_tag[$];

   always #10 clk = ~clk;

   regfile_csr_unit #(.XLEN(32), .NREG(32), .BYPASS(1'b1)) dut (
      .clk(clk), .rst(rst),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .rs1_data(rs1_data), .rs2_data(rs2_data),
      .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data),
      .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
      .csr_op(csr_op), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
      .csr_wr_suppress(csr_wr_suppress),
      .trap_pc(trap_pc), .trap_cause(trap_cause), .retire(retire),
      .mtvec_o(mtvec_o), .mepc_o(mepc_o), .mie_o(mie_o),
      .illegal_csr(illegal_csr)
   );

   regfile_csr_unit #(.XLEN(32), .NREG(32), .BYPASS(1'b0)) dut_nb (
      .clk(clk), .rst(rst),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .rs1_data(nb_rs1), .rs2_data(nb_rs2),
      .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data),
      .csr_raddr(csr_raddr), .csr_rdata(nb_csr_rdata),
      .csr_op(csr_op), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
      .csr_wr_suppress(csr_wr_suppress),
      .trap_pc(trap_pc), .trap_cause(trap_cause), .retire(retire),
      .mtvec_o(nb_mtvec), .mepc_o(nb_mepc), .mie_o(nb_mie),
      .illegal_csr(nb_illegal)
   );

   task automatic push(input string t, input logic [31:0] v);
      q_tag.push_back(t);
      q_exp.push_back(v);
   endtask

   task automatic pop_chk(input logic [31:0] obs);
      string       t;
      logic [31:0] e;
      n_vec++;
      if (q_exp.size() == 0) begin
         n_mis++;
         $error("FAIL scoreboard_empty: got %h want nothing", obs);
      end else begin
         t = q_tag.pop_front();
         e = q_exp.pop_front();
         assert (obs === e) else begin
            n_mis++;
            $error("FAIL %s: got %h want %h", t, obs, e);
         end
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [11:0] a, input logic [31:0] e,
                     input string t);
      csr_raddr = a;
      push(t, e);
      #1;
      pop_chk(csr_rdata);
   endtask

   task automatic commit(input logic [2:0] op, input logic [11:0] a,
                         input logic [31:0] d, input logic sup);
      csr_op = op;
      csr_addr = a;
      csr_wdata = d;
      csr_wr_suppress = sup;
      cyc();
      csr_op = OP_NONE;
      csr_wr_suppress = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      rs1_addr = '0; rs2_addr = '0; wb_rd = '0;
      wb_wen = 1'b0; wb_data = '0;
      csr_raddr = '0; csr_addr = '0; csr_op = OP_NONE;
      csr_wdata = '0; csr_wr_suppress = 1'b0;
      trap_pc = '0; trap_cause = '0; retire = 1'b0;
      cyc();
      cyc();

      rd(CSR_MSTATUS, 32'h1800, "rst_mstatus");
      rd(CSR_MTVEC, 32'h0, "rst_mtvec");
      rd(CSR_MEPC, 32'h0, "rst_mepc");
      rd(CSR_MCYCLE, 32'h0, "rst_mcycle");
      push("rst_illegal", 32'h0);
      #1 pop_chk({31'b0, illegal_csr});
      rst = 1'b0;
      rd(CSR_MCYCLE, 32'h0, "mcycle_before_edge");
      cyc();
      rd(CSR_MCYCLE, 32'h1, "mcycle_first_inc");

      wb_wen = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF;
      rs1_addr = 5'd5;
      push("bypass_on", 32'hDEADBEEF);
      push("bypass_off", 32'h0);
      #1;
      pop_chk(rs1_data);
      pop_chk(nb_rs1);
      cyc();
      wb_wen = 1'b0;
      push("x5_stored", 32'hDEADBEEF);
      push("x5_stored_nb", 32'hDEADBEEF);
      #1;
      pop_chk(rs1_data);
      pop_chk(nb_rs1);

      wb_wen = 1'b1; wb_rd = 5'd0; wb_data = 32'h1234; rs2_addr = 5'd0;
      push("x0_same_cycle", 32'h0);
      #1 pop_chk(rs2_data);
      cyc();
      wb_wen = 1'b0;
      push("x0_next", 32'h0);
      push("x0_next_nb", 32'h0);
      #1;
      pop_chk(rs2_data);
      pop_chk(nb_rs2);

      wb_wen = 1'b1; wb_rd = 5'd5; wb_data = 32'h11112222;
      csr_op = OP_RW; csr_addr = CSR_MSCRATCH; csr_wdata = 32'hCAFEF00D;
      push("nb_stored_old", 32'hDEADBEEF);
      #1 pop_chk(nb_rs1);
      rd(CSR_MSCRATCH, 32'h0, "csr_no_forward");
      cyc();
      wb_wen = 1'b0; csr_op = OP_NONE;
      rd(CSR_MSCRATCH, 32'hCAFEF00D, "dual_csr");
      push("dual_gpr", 32'h11112222);
      #1 pop_chk(rs1_data);

      commit(OP_RW, CSR_MSTATUS, 32'hFFFFFFFF, 1'b0);
      rd(CSR_MSTATUS, 32'h1888, "mstatus_mask");
      commit(OP_RW, CSR_MSTATUS, 32'h8, 1'b0);
      rd(CSR_MSTATUS, 32'h1808, "mstatus_mie");
      push("mie_o_set", 32'h1);
      #1 pop_chk({31'b0, mie_o});
      trap_pc = 32'h80000103; trap_cause = 32'd11;
      commit(OP_ECALL, 12'h0, 32'h0, 1'b0);
      rd(CSR_MEPC, 32'h80000100, "ecall_mepc");
      rd(CSR_MCAUSE, 32'd11, "ecall_mcause");
      rd(CSR_MSTATUS, 32'h1880, "ecall_mstatus");
      push("ecall_mepc_o", 32'h80000100);
      #1 pop_chk(mepc_o);
      commit(OP_MRET, 12'h0, 32'h0, 1'b0);
      rd(CSR_MSTATUS, 32'h1888, "mret_mstatus");
      rd(CSR_MEPC, 32'h80000100, "mret_mepc");

      commit(OP_RS, CSR_MTVEC, 32'h3, 1'b0);
      rd(CSR_MTVEC, 32'h0, "mtvec_rs_low");
      commit(OP_RW, CSR_MTVEC, 32'h110, 1'b0);
      rd(CSR_MTVEC, 32'h110, "mtvec_rw");
      commit(OP_RC, CSR_MTVEC, 32'h10, 1'b0);
      rd(CSR_MTVEC, 32'h100, "mtvec_rc");
      commit(OP_RS, CSR_MTVEC, 32'hF000, 1'b1);
      rd(CSR_MTVEC, 32'h100, "mtvec_rs_suppress");
      commit(OP_RW, CSR_MTVEC, 32'h207, 1'b1);
      rd(CSR_MTVEC, 32'h204, "mtvec_rw_suppress");
      push("mtvec_o", 32'h204);
      #1 pop_chk(mtvec_o);
      commit(OP_RW, CSR_MEPC, 32'h7, 1'b0);
      rd(CSR_MEPC, 32'h4, "mepc_align");

      commit(OP_RW, CSR_MCYCLEH, 32'h0, 1'b0);
      commit(OP_RW, CSR_MCYCLE, 32'hFFFFFFFF, 1'b0);
      rd(CSR_MCYCLE, 32'hFFFFFFFF, "mcycle_written");
      rd(CSR_MCYCLEH, 32'h0, "mcycleh_held");
      cyc();
      rd(CSR_MCYCLE, 32'h0, "mcycle_carry_lo");
      rd(CSR_MCYCLEH, 32'h1, "mcycle_carry_hi");

      commit(OP_RW, CSR_MINSTRET, 32'd5, 1'b0);
      retire = 1'b1;
      repeat (3) cyc();
      retire = 1'b0;
      rd(CSR_MINSTRET, 32'd8, "minstret_count");
      retire = 1'b1;
      commit(OP_RW, CSR_MINSTRET, 32'd100, 1'b0);
      retire = 1'b0;
      rd(CSR_MINSTRET, 32'd100, "minstret_write_wins");
      commit(OP_RW, CSR_MINSTRETH, 32'hFFFFFFFF, 1'b0);
      commit(OP_RW, CSR_MINSTRET, 32'hFFFFFFFF, 1'b0);
      retire = 1'b1;
      cyc();
      retire = 1'b0;
      rd(CSR_MINSTRET, 32'h0, "minstret_wrap_lo");
      rd(CSR_MINSTRETH, 32'h0, "minstret_wrap_hi");

      csr_raddr = 12'h7C0;
      push("illegal_before", 32'h0);
      csr_op = OP_RW; csr_addr = 12'h7C0; csr_wdata = 32'hFFFFFFFF;
      #1 pop_chk({31'b0, illegal_csr});
      cyc();
      csr_op = OP_NONE;
      push("illegal_pulse", 32'h1);
      #1 pop_chk({31'b0, illegal_csr});
      rd(12'h7C0, 32'h0, "unimpl_reads_zero");
      rd(CSR_MTVEC, 32'h204, "illegal_mtvec_kept");
      rd(CSR_MSCRATCH, 32'hCAFEF00D, "illegal_mscratch_kept");
      rd(CSR_MSTATUS, 32'h1888, "illegal_mstatus_kept");
      cyc();
      push("illegal_clears", 32'h0);
      #1 pop_chk({31'b0, illegal_csr});
      commit(3'd6, CSR_MSCRATCH, 32'h0, 1'b0);
      rd(CSR_MSCRATCH, 32'hCAFEF00D, "op6_noop");
      push("op6_no_illegal", 32'h0);
      #1 pop_chk({31'b0, illegal_csr});

      trap_pc = 32'h1000; trap_cause = 32'd8;
      csr_op = OP_ECALL;
      rs1_addr = 5'd5;
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      csr_op = OP_NONE;
      rd(CSR_MEPC, 32'h0, "rstmid_mepc");
      rd(CSR_MCAUSE, 32'h0, "rstmid_mcause");
      rd(CSR_MSTATUS, 32'h1800, "rstmid_mstatus");
      rd(CSR_MTVEC, 32'h0, "rstmid_mtvec");
      rd(CSR_MSCRATCH, 32'h0, "rstmid_mscratch");
      rd(CSR_MCYCLE, 32'h0, "rstmid_mcycle");
      rd(CSR_MINSTRET, 32'h0, "rstmid_minstret");
      push("rstmid_x5", 32'h0);
      #1 pop_chk(rs1_data);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule

// File: doc/regfile_csr_unit.md
REGFILE_CSR_UNIT -- requirements
Module: regfile_csr_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width in bits; 32 is the only supported value.
REQ-002 SHALL have parameter NREG, default 32, number of GPRs; 16 (RV32E) or 32; AW = clog2(NREG).
REQ-003 SHALL have parameter BYPASS, default 1, which enables write-to-read forwarding on the GPR read ports.
REQ-004 SHALL have ports, one per line as name direction width meaning; clk and rst come first. One clock; reset is synchronous and active-high.
 clk  in  1  clock, rising edge
 rst  in  1  synchronous active-high reset
 rs1_addr  in  AW  GPR read port A address
 rs2_addr  in  AW  GPR read port B address
 rs1_data  out  XLEN  port A data, combinational
 rs2_data  out  XLEN  port B data, combinational
 wb_wen  in  1  GPR write enable
 wb_rd  in  AW  GPR write address
 wb_data  in  XLEN  GPR write data
 csr_raddr  in  12  CSR read address, decode stage
 csr_rdata  out  XLEN  CSR read data, combinational
 csr_op  in  3  commit op: NONE, RW, RS, RC, ECALL, MRET
 csr_addr  in  12  commit CSR address
 csr_wdata  in  XLEN  commit operand
 csr_wr_suppress  in  1  RS/RC with rs1=x0: read only, no write
 trap_pc  in  XLEN  PC of the ECALL instruction
 trap_cause  in  XLEN  cause value for ECALL
 retire  in  1  one instruction retired this cycle
 mtvec_o  out  XLEN  current mtvec
 mepc_o  out  XLEN  current mepc
 mie_o  out  1  mstatus.MIE
 illegal_csr  out  1  registered one-cycle pulse: RW/RS/RC hit an unimplemented address

Function
REQ-005 SHALL return 0 for reads of x0 on both ports, and SHALL ignore writes to x0.
REQ-006 SHALL, when BYPASS=1, wb_wen=1 and wb_rd equals a read address (not 0), return wb_data on that port in the same cycle; when BYPASS=0, SHALL return the stored value.
REQ-007 SHALL update a GPR on the rising clk edge when wb_wen=1 and wb_rd is not 0.
REQ-008 SHALL implement mstatus, mtvec, mscratch, mepc, mcause, mcycle/mcycleh and minstret/minstreth.
REQ-009 SHALL return 0 on csr_rdata for unimplemented addresses.
REQ-010 SHALL never forward committing CSR values to csr_rdata; it reflects state only.
REQ-011 SHALL perform commit writes on the edge: RW writes wdata; RS writes old OR wdata; RC writes old AND NOT wdata.
REQ-012 SHALL skip the write when csr_wr_suppress=1 for RS/RC; suppress SHALL be ignored for RW.
REQ-013 SHALL make mstatus writable only in MIE (bit 3) and MPIE (bit 7); MPP (bits 12:11) SHALL read as 2'b11 at all times, and all other bits SHALL read 0.
REQ-014 SHALL force mepc and mtvec bits [1:0] to 0 on every write.
REQ-015 SHALL, on ECALL: mepc<=trap_pc with [1:0] cleared; mcause<=trap_cause; MPIE<=MIE; MIE<=0.
REQ-016 SHALL, on MRET: MIE<=MPIE; MPIE<=1; mepc unchanged.
REQ-017 SHALL make the 64-bit mcycle increment every cycle out of reset and wrap from all-ones to 0.
REQ-018 SHALL make the 64-bit minstret increment when retire=1 and wrap likewise.
REQ-019 SHALL, on a CSR write to a counter half in the same cycle as its increment, let the write win for that half, and SHALL not increment the other half that cycle.
REQ-020 SHALL make a GPR writeback and a CSR commit in the same cycle both take effect independently.
REQ-021 SHALL drive illegal_csr high one cycle after RW/RS/RC to an unimplemented address, and SHALL change no state.
REQ-022 SHALL treat csr_op NONE and codes 6-7 as no-ops.

Reset
REQ-023 SHALL, while rst=1 at a clk edge: all GPRs 0; mstatus 0x1800; mtvec, mscratch, mepc, mcause 0; counters 0; illegal_csr 0.
REQ-024 SHALL give rst priority over any simultaneous write, commit, retire or increment.
REQ-025 SHALL make the first mcycle increment happen on the first edge after rst deasserts.

Structure
REQ-026 SHALL place the CSR address constants (0x300, 0x305, 0x340, 0x341, 0x342, 0xB00, 0xB80, 0xB02, 0xB82), the csr_op encodings and the mstatus bit indices in the shared package.
REQ-027 SHALL use one sub-module, csr_counter64 (64-bit counter with increment, half-write and wrap), instantiated twice.

Verification
REQ-028 SHALL cover: write x5=0xDEADBEEF with rs1_addr=5 in the same cycle -> rs1_data=0xDEADBEEF that cycle (BYPASS=1); old value when BYPASS=0.
REQ-029 SHALL cover: wb_rd=0, data 0x1234 -> rs2_addr=0 reads 0 next cycle.
REQ-030 SHALL cover: mstatus=0x8 (MIE=1), ECALL pc=0x80000103 cause=11 -> mepc=0x80000100, mcause=11, mstatus=0x1880; then MRET -> mstatus=0x1888.
REQ-031 SHALL cover: RS mtvec 0x3 then RC with wdata 0x10 on mtvec=0x110 -> mtvec 0x0 then 0x100; RS with suppress -> unchanged.
REQ-032 SHALL cover: write mcycle=0xFFFFFFFF with mcycleh=0 -> after 1 increment, mcycleh=1 and mcycle=0; RW to 0x7C0 -> illegal_csr pulse, CSRs unchanged.
REQ-033 SHALL cover: assert rst mid-ECALL commit -> all reset values, mepc=0.
